// File: rtl/alu_op_scheduler_pkg.sv
// Shared definitions for the ALU operation scheduler: opcodes, FSM states
// and the shift-opcode classifier.
package alu_sched_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_LSH = 3'd2;
  localparam logic [2:0] OP_RSH = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_ILL = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  function automatic logic is_shift(input logic [2:0] op);
    return (op == OP_LSH) || (op == OP_RSH);
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter; the last-served pointer moves only when the
// current grant is consumed (advance).
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // last == 1 means requester 1 was served last, so requester 0 wins a tie
  logic last;

  always_ff @(posedge clk) begin
    if (!reset)
      last <= 1'b1;
    else if (advance)
      last <= grant[1];
  end

  always_comb begin
    grant = '0;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/alu_op_scheduler.sv
// Arbitrates two requesters onto one registered ALU, sequences the strobes
// and shifter load, and returns the captured result on a valid/ready port.
module alu_op_scheduler
  import alu_sched_pkg::*;
#(
  parameter int DATA_W    = 4,
  parameter int ALU_LAT   = 1,
  parameter int SHIFT_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [2:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [2:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_ovf,
  output logic              rsp_err,
  output logic              alu_add,
  output logic              alu_sub,
  output logic              alu_lsh,
  output logic              alu_rsh,
  output logic              alu_and,
  output logic              alu_or,
  output logic              alu_xor,
  output logic              alu_shift_load,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_overflow
);

  localparam int MAX_LAT = (SHIFT_LAT > ALU_LAT) ? SHIFT_LAT : ALU_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic             id_q;
  logic [1:0]       grant;
  logic             accept;
  logic [2:0]       sel_op;

  // Requests are only visible to the arbiter while idle and out of reset
  rr_arbiter_2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     ({req1_valid, req0_valid} & {2{reset && (state == S_IDLE)}}),
    .advance (accept),
    .grant   (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign accept     = |grant;
  assign sel_op     = grant[1] ? req1_op : req0_op;
  assign rsp_id     = id_q;

  always_ff @(posedge clk) begin
    if (!reset)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:
        if (accept) begin
          if (sel_op == OP_ILL)      state_n = S_RESP;
          else if (is_shift(sel_op)) state_n = S_LOAD;
          else                       state_n = S_ISSUE;
        end
      S_LOAD:  state_n = S_ISSUE;
      S_ISSUE: if (cnt == '0) state_n = S_WAIT;
      S_WAIT:  if (cnt == '0) state_n = S_RESP;
      S_RESP:  if (rsp_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // cnt is preloaded with the strobe hold length on accept, then with the
  // ALU latency on leaving ISSUE; it always counts down to zero, never wraps
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt      <= '0;
      op_q     <= '0;
      id_q     <= 1'b0;
      alu_in1  <= '0;
      alu_in2  <= '0;
      rsp_data <= '0;
      rsp_ovf  <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE:
          if (accept) begin
            op_q    <= sel_op;
            id_q    <= grant[1];
            alu_in1 <= grant[1] ? req1_a : req0_a;
            alu_in2 <= grant[1] ? req1_b : req0_b;
            cnt     <= is_shift(sel_op) ? CNT_W'(SHIFT_LAT - 1) : '0;
            if (sel_op == OP_ILL) begin
              rsp_data <= '0;
              rsp_ovf  <= 1'b0;
              rsp_err  <= 1'b1;
            end
          end
        S_ISSUE:
          if (cnt == '0) cnt <= CNT_W'(ALU_LAT - 1);
          else           cnt <= cnt - CNT_W'(1);
        S_WAIT:
          if (cnt == '0) begin
            rsp_data <= alu_out;
            rsp_ovf  <= alu_overflow;
            rsp_err  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        default: ;
      endcase
    end
  end

  always_comb begin
    alu_add        = 1'b0;
    alu_sub        = 1'b0;
    alu_lsh        = 1'b0;
    alu_rsh        = 1'b0;
    alu_and        = 1'b0;
    alu_or         = 1'b0;
    alu_xor        = 1'b0;
    alu_shift_load = (state == S_LOAD);
    rsp_valid      = (state == S_RESP);
    if (state == S_ISSUE) begin
      unique case (op_q)
        OP_ADD:  alu_add = 1'b1;
        OP_SUB:  alu_sub = 1'b1;
        OP_LSH:  alu_lsh = 1'b1;
        OP_RSH:  alu_rsh = 1'b1;
        OP_AND:  alu_and = 1'b1;
        OP_OR:   alu_or  = 1'b1;
        OP_XOR:  alu_xor = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
